aes_block_sequencer: RTL
========================

# aes_block_sequencer

Datapath sequencer between the accelerator's memory-mapped buffers and the AES core. On `start_i` it reads the data buffer word by word and packs the words into 128-bit blocks, zero-padding the final partial block. It hands each block to the AES core over a valid/ready handshake, captures the 128-bit result and unpacks it into the result buffer. It also maintains the result length that software reads back.

## Interface
- `BUS_WIDTH`, 32: bus, buffer word and length-register width.
- `BLOCK_WIDTH`, 128: AES block width; fixed 4 words per block.
- `BUF_ADDR_W`, 10: word-address width of the data and result buffers; capacity = 2^BUF_ADDR_W words.
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `start_i` in 1: one-cycle start request; sampled only in IDLE.
- `data_len_i` in BUS_WIDTH: message length in bytes; sampled with `start_i`.
- `busy_o` out 1: high in every state except IDLE.
- `done_o` out 1: one-cycle pulse at the end of a run, including error runs.
- `err_o` out 1: length-overflow flag, sticky until the next accepted start.
- `dbuf_rd_o` out 1: data-buffer read strobe.
- `dbuf_addr_o` out BUF_ADDR_W: data-buffer word address.
- `dbuf_data_i` in BUS_WIDTH: read data, valid exactly one cycle after `dbuf_rd_o`.
- `blk_valid_o` out 1, `blk_ready_i` in 1, `blk_data_o` out BLOCK_WIDTH: plaintext block to the AES core.
- `res_valid_i` in 1, `res_ready_o` out 1, `res_data_i` in BLOCK_WIDTH: result block from the AES core.
- `rbuf_we_o` out 1, `rbuf_addr_o` out BUF_ADDR_W, `rbuf_data_o` out BUS_WIDTH: result-buffer write port.
- `result_len_o` out BUS_WIDTH: bytes written to the result buffer in the current or last run.

## Operation
- States: IDLE, FETCH, SEND, WAIT_RES, WRITE, DONE.
- **IDLE.**
  - `start_i` with `data_len_i` == 0: go to DONE. No reads; `result_len_o` = 0.
  - `start_i` with `data_len_i` > 4·2^BUF_ADDR_W: set `err_o`, go to DONE. No reads.
  - Any other `start_i`: clear `err_o` and `result_len_o`, latch the length, compute `nblk` = ceil(len/16), reset the word pointer, go to FETCH.
- **FETCH.**
  - Issue 4 reads at consecutive word addresses; capture each returned word.
  - The first word of a block occupies bits [127:96]. The lowest-address byte of a word occupies bits [31:24].
  - Bytes at index ≥ len are forced to 0; this applies only to the last block.
  - Go to SEND after the 4th word is captured.
- **SEND.** Hold `blk_valid_o` and a stable `blk_data_o` until `blk_ready_i`, then go to WAIT_RES.
- **WAIT_RES.** `res_ready_o` = 1. On `res_valid_i`, register `res_data_i` and go to WRITE. `res_valid_i` in any other state is not acknowledged.
- **WRITE.**
  - 4 consecutive writes, most-significant word first, to result-buffer words 4·blk .. 4·blk+3.
  - `result_len_o` += 16 on the cycle of the 4th write.
  - Then go to FETCH if blocks remain, else to DONE.
- **DONE.** `done_o` = 1 for one cycle, then IDLE.
- `start_i` while busy is ignored.
- Exactly one block is in flight at a time.

## Timing
- Reset values: every output is 0, state is IDLE, and all counters are 0.
- Reset mid-run returns to IDLE on the next edge. Partial result-buffer contents are left as they are.
- FETCH lasts 5 cycles: reads on cycles 0–3, data captured on cycles 1–4.
- SEND lasts at least 1 cycle. `blk_valid_o` is asserted the cycle after the 4th capture.
- WRITE lasts exactly 4 cycles. `done_o` follows the final write by one cycle.
- Per-block latency = 5 + SEND + WAIT_RES + 4 cycles.
- If `blk_ready_i` and `blk_valid_o` rise together, the transfer completes that cycle.
- If `res_valid_i` is already high on entry to WAIT_RES, the result is captured on that first cycle.
- Word pointers use BUF_ADDR_W bits. A maximum-length run ends exactly at the last word, with no wrap.

## Structure
- Package `crypto_acc_pkg` holds:
  - `BLOCK_WIDTH` and `WORDS_PER_BLOCK` = 4;
  - the `seq_state_t` enum;
  - a `byte_mask_f(len_rem)` function returning the 16-bit valid-byte mask.
- One sub-module, `blk_word_packer`: a shift-in register of 4 words with byte masking. The same shape is reused for unpacking.

## Test plan
- len 32: 8 reads at words 0..7 → 2 blocks. AES stub returns block XOR all-ones → 8 result writes of the inverted words; `result_len_o` = 32; one `done_o`.
- len 5, data word0 = 0x11223344, word1 = 0x55667788 → `blk_data_o` = 0x11223344_55000000_00000000_00000000; `result_len_o` = 16.
- len 0 → `done_o` on the 2nd cycle after start; no `dbuf_rd_o`; `err_o` = 0.
- len 4097 with BUF_ADDR_W = 10 → `err_o` = 1 and `done_o` with no reads; a next start with len 16 clears `err_o`.
- `blk_ready_i` held low 7 cycles with `res_valid_i` delayed 3 cycles → `blk_data_o` stable throughout; no extra writes.
- `rst_i` asserted in WRITE after 2 of 4 writes → all outputs 0 next cycle; a new start with len 16 runs normally.

Source files
------------

// File: rtl/crypto_acc_pkg.sv
// -----------------------------------------------------------------------------
// crypto_acc_pkg
// Shared types and helpers for the crypto accelerator datapath.
//   BLOCK_WIDTH     : AES block width in bits
//   WORDS_PER_BLOCK : bus words packed into one AES block
//   seq_state_t     : block sequencer states
//   byte_mask_f     : valid-byte mask of a block given the bytes still to send
// -----------------------------------------------------------------------------
package crypto_acc_pkg;

   localparam int BLOCK_WIDTH     = 128;
   localparam int WORDS_PER_BLOCK = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SEND,
      S_WAIT_RES,
      S_WRITE,
      S_DONE
   } seq_state_t;

   // Bit 15 is block byte 0 (lowest address). A byte is valid while its
   // index within the block is below the remaining message length.
   function automatic logic [15:0] byte_mask_f(input logic [31:0] len_rem);
      logic [15:0] m;
      m = '0;
      for (int i = 0; i < 16; i++) begin
         m[15-i] = (len_rem > 32'(i));
      end
      return m;
   endfunction

endpackage

// File: rtl/blk_word_packer.sv
// -----------------------------------------------------------------------------
// blk_word_packer
// Four-word shift register. Packing: words shift in at the bottom so the first
// word ends up in the top slot; disabled bytes are zeroed on the way in.
// Unpacking: load a whole block, read the top word, shift with byte_en_i = 0.
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i/blk_i : parallel load of a full block (has priority over shift)
//   shift_i      : shift one word in at the bottom
//   word_i       : word shifted in
//   byte_en_i    : per-byte enable for word_i, bit MSB = bits [WORD_W-1 -: 8]
//   blk_o        : register contents, first word in the top slot
// -----------------------------------------------------------------------------
module blk_word_packer
   import crypto_acc_pkg::*;
#(
   parameter int WORD_W = 32
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              load_i,
   input  logic [WORDS_PER_BLOCK*WORD_W-1:0] blk_i,
   input  logic                              shift_i,
   input  logic [WORD_W-1:0]                 word_i,
   input  logic [WORD_W/8-1:0]               byte_en_i,
   output logic [WORDS_PER_BLOCK*WORD_W-1:0] blk_o
);

   logic [WORD_W-1:0] word_masked;

   always_comb begin
      word_masked = '0;
      for (int i = 0; i < WORD_W/8; i++) begin
         if (byte_en_i[i]) word_masked[i*8 +: 8] = word_i[i*8 +: 8];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         blk_o <= '0;
      end else if (load_i) begin
         blk_o <= blk_i;
      end else if (shift_i) begin
         blk_o <= {blk_o[(WORDS_PER_BLOCK-1)*WORD_W-1:0], word_masked};
      end
   end

endmodule

// File: rtl/aes_block_sequencer.sv
// -----------------------------------------------------------------------------
// aes_block_sequencer
// Reads a message from the data buffer, packs it into zero-padded 128-bit
// blocks, passes each block through the AES core one at a time and unpacks
// the results into the result buffer.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   start_i, data_len_i       : run request and message length in bytes
//   busy_o, done_o, err_o     : status (done pulse, sticky length overflow)
//   dbuf_rd_o/addr_o/data_i   : data-buffer read port, one-cycle read latency
//   blk_valid_o/ready_i/data_o: plaintext block to the AES core
//   res_valid_i/ready_o/data_i: result block from the AES core
//   rbuf_we_o/addr_o/data_o   : result-buffer write port
//   result_len_o              : bytes written to the result buffer
// -----------------------------------------------------------------------------
module aes_block_sequencer
   import crypto_acc_pkg::*;
#(
   parameter int BUS_WIDTH  = 32,
   parameter int BUF_ADDR_W = 10
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [BUS_WIDTH-1:0]   data_len_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o,
   output logic                   dbuf_rd_o,
   output logic [BUF_ADDR_W-1:0]  dbuf_addr_o,
   input  logic [BUS_WIDTH-1:0]   dbuf_data_i,
   output logic                   blk_valid_o,
   input  logic                   blk_ready_i,
   output logic [BLOCK_WIDTH-1:0] blk_data_o,
   input  logic                   res_valid_i,
   output logic                   res_ready_o,
   input  logic [BLOCK_WIDTH-1:0] res_data_i,
   output logic                   rbuf_we_o,
   output logic [BUF_ADDR_W-1:0]  rbuf_addr_o,
   output logic [BUS_WIDTH-1:0]   rbuf_data_o,
   output logic [BUS_WIDTH-1:0]   result_len_o
);

   // Largest message the data buffer can hold, in bytes.
   localparam logic [BUS_WIDTH-1:0] MAX_LEN = BUS_WIDTH'((BUS_WIDTH/8) * (2 ** BUF_ADDR_W));

   seq_state_t           state;
   logic [2:0]           fcnt;
   logic [1:0]           wcnt;
   logic [BUS_WIDTH-1:0] nblk;
   logic [BUS_WIDTH-1:0] blk_cnt;
   logic [BUS_WIDTH-1:0] rem_len;

   logic [15:0]          blk_mask;
   logic [1:0]           word_idx;
   logic [3:0]           word_be;
   logic                 pack_shift;
   logic                 unpack_load;
   logic [BLOCK_WIDTH-1:0] unpack_blk;

   assign busy_o = (state != S_IDLE);

   // Captures in FETCH happen on fcnt 1..4 for words 0..3 of the block.
   assign pack_shift  = (state == S_FETCH) && (fcnt != 3'd0);
   assign word_idx    = fcnt[1:0] - 2'd1;
   assign blk_mask    = byte_mask_f(32'(rem_len));
   assign unpack_load = (state == S_WAIT_RES) && res_valid_i;

   always_comb begin
      word_be = 4'hF;
      case (word_idx)
         2'd0: word_be = blk_mask[15:12];
         2'd1: word_be = blk_mask[11:8];
         2'd2: word_be = blk_mask[7:4];
         2'd3: word_be = blk_mask[3:0];
         default: word_be = 4'hF;
      endcase
   end

   blk_word_packer #(.WORD_W(BUS_WIDTH)) u_packer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (1'b0),
      .blk_i     ('0),
      .shift_i   (pack_shift),
      .word_i    (dbuf_data_i),
      .byte_en_i (word_be),
      .blk_o     (blk_data_o)
   );

   blk_word_packer #(.WORD_W(BUS_WIDTH)) u_unpacker (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (unpack_load),
      .blk_i     (res_data_i),
      .shift_i   (state == S_WRITE),
      .word_i    ('0),
      .byte_en_i ('0),
      .blk_o     (unpack_blk)
   );

   assign rbuf_data_o = unpack_blk[BLOCK_WIDTH-1 -: BUS_WIDTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         fcnt         <= '0;
         wcnt         <= '0;
         nblk         <= '0;
         blk_cnt      <= '0;
         rem_len      <= '0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         dbuf_rd_o    <= 1'b0;
         dbuf_addr_o  <= '0;
         blk_valid_o  <= 1'b0;
         res_ready_o  <= 1'b0;
         rbuf_we_o    <= 1'b0;
         rbuf_addr_o  <= '0;
         result_len_o <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  if (data_len_i == '0) begin
                     err_o        <= 1'b0;
                     result_len_o <= '0;
                     done_o       <= 1'b1;
                     state        <= S_DONE;
                  end else if (data_len_i > MAX_LEN) begin
                     err_o  <= 1'b1;
                     done_o <= 1'b1;
                     state  <= S_DONE;
                  end else begin
                     err_o        <= 1'b0;
                     result_len_o <= '0;
                     rem_len      <= data_len_i;
                     nblk         <= (data_len_i + BUS_WIDTH'(15)) >> 4;
                     blk_cnt      <= '0;
                     dbuf_addr_o  <= '0;
                     rbuf_addr_o  <= '0;
                     fcnt         <= '0;
                     dbuf_rd_o    <= 1'b1;
                     state        <= S_FETCH;
                  end
               end
            end

            // ---- FETCH: reads on fcnt 0..3, captures on fcnt 1..4 ----
            S_FETCH: begin
               fcnt      <= fcnt + 3'd1;
               dbuf_rd_o <= (fcnt < 3'd3);
               if (dbuf_rd_o) dbuf_addr_o <= dbuf_addr_o + BUF_ADDR_W'(1);
               if (fcnt == 3'd4) begin
                  blk_valid_o <= 1'b1;
                  state       <= S_SEND;
               end
            end

            // ---- SEND: block held stable until the core takes it ----
            S_SEND: begin
               if (blk_ready_i) begin
                  blk_valid_o <= 1'b0;
                  res_ready_o <= 1'b1;
                  state       <= S_WAIT_RES;
               end
            end

            // ---- WAIT_RES: result captured into the unpacker ----
            S_WAIT_RES: begin
               if (res_valid_i) begin
                  res_ready_o <= 1'b0;
                  rbuf_we_o   <= 1'b1;
                  wcnt        <= '0;
                  state       <= S_WRITE;
               end
            end

            // ---- WRITE: four result words, most significant first ----
            S_WRITE: begin
               wcnt        <= wcnt + 2'd1;
               rbuf_addr_o <= rbuf_addr_o + BUF_ADDR_W'(1);
               if (wcnt == 2'd3) begin
                  rbuf_we_o    <= 1'b0;
                  result_len_o <= result_len_o + BUS_WIDTH'(16);
                  blk_cnt      <= blk_cnt + BUS_WIDTH'(1);
                  rem_len      <= rem_len - BUS_WIDTH'(16);
                  if ((blk_cnt + BUS_WIDTH'(1)) < nblk) begin
                     fcnt      <= '0;
                     dbuf_rd_o <= 1'b1;
                     state     <= S_FETCH;
                  end else begin
                     done_o <= 1'b1;
                     state  <= S_DONE;
                  end
               end
            end

            S_DONE: begin
               state <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
